// File: rtl/alu_muldiv_ctrl.sv
// ALU control decoder with an iterative multiply/divide engine and HI/LO registers.
// One shift-add or restoring-divide step per cycle, followed by a sign-fix cycle.
//
// state  | meaning
// S_IDLE | waiting for a muldiv op, mthi/mtlo write HI/LO directly
// S_MUL  | shift-add iteration on the 2*WIDTH accumulator
// S_DIV  | restoring divide iteration, one quotient bit per cycle
// S_FIX  | sign correction, HI/LO write, Done pulse
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_alu_op,
  input  logic [5:0]       i_fn_field,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic [3:0]       o_alu_ctrl,
  output logic [WIDTH-1:0] o_mf_data,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_rtype, w_mult, w_multu, w_div, w_divu;
  logic               w_mfhi, w_mflo, w_mthi, w_mtlo, w_md_any, w_signed;
  logic               w_idle, w_accept_mul, w_accept_div, w_div_zero;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_part;
  logic [WIDTH+1:0]   w_div_diff;
  logic               w_div_ge;
  logic [WIDTH:0]     w_div_upper;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign w_rtype  = i_alu_op[1];
  assign w_mult   = w_rtype & (i_fn_field == FN_MULT);
  assign w_multu  = w_rtype & (i_fn_field == FN_MULTU);
  assign w_div    = w_rtype & (i_fn_field == FN_DIV);
  assign w_divu   = w_rtype & (i_fn_field == FN_DIVU);
  assign w_mfhi   = w_rtype & (i_fn_field == FN_MFHI);
  assign w_mflo   = w_rtype & (i_fn_field == FN_MFLO);
  assign w_mthi   = w_rtype & (i_fn_field == FN_MTHI);
  assign w_mtlo   = w_rtype & (i_fn_field == FN_MTLO);
  assign w_md_any = w_mult | w_multu | w_div | w_divu | w_mfhi | w_mflo | w_mthi | w_mtlo;
  assign w_signed = w_mult | w_div;

  assign w_idle       = (r_state == S_IDLE);
  assign w_accept_mul = w_idle & i_start & (w_mult | w_multu);
  assign w_accept_div = w_idle & i_start & (w_div | w_divu);
  assign w_div_zero   = (i_src_b == '0);

  assign w_a_neg = w_signed & i_src_a[WIDTH-1];
  assign w_b_neg = w_signed & i_src_b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -i_src_a : i_src_a;
  assign w_mag_b = w_b_neg ? -i_src_b : i_src_b;

  // The top accumulator bit is always 0 between steps, so the add cannot overflow.
  assign w_mul_sum = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_opnd} : '0);

  assign w_div_part  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = {1'b0, w_div_part} - {2'b00, r_opnd};
  assign w_div_ge    = ~w_div_diff[WIDTH+1];
  assign w_div_upper = w_div_ge ? w_div_diff[WIDTH:0] : w_div_part;

  assign w_prod     = r_acc[2*WIDTH-1:0];
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept_mul)      w_next = S_MUL;
        else if (w_accept_div) w_next = w_div_zero ? S_FIX : S_DIV;
      end
      S_MUL, S_DIV: if (r_count == CW'(1)) w_next = S_FIX;
      S_FIX:        w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept_mul) begin
            r_opnd   <= w_mag_a;
            r_acc    <= {{(WIDTH+1){1'b0}}, w_mag_b};
            r_count  <= CW'(WIDTH);
            r_is_div <= 1'b0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= 1'b0;
          end else if (w_accept_div) begin
            r_count  <= CW'(WIDTH);
            r_is_div <= 1'b1;
            if (w_div_zero) begin
              // Preload the forced result so FIX writes it unchanged.
              r_acc   <= {1'b0, i_src_a, {WIDTH{1'b1}}};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_opnd  <= w_mag_b;
              r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_a};
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end
          end else if (i_start & w_mthi) begin
            r_hi <= i_src_a;
          end else if (i_start & w_mtlo) begin
            r_lo <= i_src_a;
          end
        end
        S_MUL: begin
          r_acc   <= {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
          r_count <= r_count - CW'(1);
        end
        S_DIV: begin
          r_acc   <= {w_div_upper, r_acc[WIDTH-2:0], w_div_ge};
          r_count <= r_count - CW'(1);
        end
        S_FIX: begin
          if (r_is_div) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_done <= 1'b1;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  always_comb begin
    o_alu_ctrl = 4'b0000;
    if (i_alu_op[1]) begin
      case (i_fn_field[3:0])
        4'b0000: o_alu_ctrl = 4'b0010;
        4'b0010: o_alu_ctrl = 4'b0110;
        4'b0100: o_alu_ctrl = 4'b0000;
        4'b0101: o_alu_ctrl = 4'b0001;
        4'b1010: o_alu_ctrl = 4'b0111;
        4'b0111: o_alu_ctrl = 4'b1100;
        default: o_alu_ctrl = 4'b0000;
      endcase
    end else if (i_alu_op[0]) begin
      o_alu_ctrl = 4'b0110;
    end else begin
      o_alu_ctrl = 4'b0010;
    end
  end

  always_comb begin
    o_mf_data = '0;
    if (w_mfhi)      o_mf_data = r_hi;
    else if (w_mflo) o_mf_data = r_lo;
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = ~w_idle;
  assign o_done  = r_done;
  assign o_stall = i_start & o_busy & w_md_any;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: decode table, directed muldiv table,
// hand-written corner sequences and random ops against an arithmetic model.
module tb_alu_muldiv_ctrl;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [5:0]  fn_field;
  logic        start;
  logic [31:0] src_a, src_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] mf_data, hi, lo;
  logic        busy, done, stall;

  int n_vec = 0;
  int n_err = 0;

  alu_muldiv_ctrl #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_alu_op(alu_op), .i_fn_field(fn_field),
    .i_start(start), .i_src_a(src_a), .i_src_b(src_b), .o_alu_ctrl(alu_ctrl),
    .o_mf_data(mf_data), .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done),
    .o_stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
  } alu_vec_t;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a, b, exp_hi, exp_lo;
    int          lat;
  } md_vec_t;

  alu_vec_t alu_tab[10];
  md_vec_t  md_tab[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (fn == FN_MULT) begin
      q = sa * sb;
      return q;
    end
    if (fn == FN_MULTU) begin
      u = {32'b0, a} * {32'b0, b};
      return u;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (fn == FN_DIV) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = 2'b10; fn_field = fn; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; fn_field = FN_ADD;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, cnt;
    logic [63:0] exp;
    logic [5:0] fns[4];
    logic [31:0] specials[5];
    logic [31:0] ra, rb;

    alu_tab[0] = '{2'b00, 6'b000000, 4'b0010};
    alu_tab[1] = '{2'b01, 6'b100000, 4'b0110};
    alu_tab[2] = '{2'b10, 6'b100000, 4'b0010};
    alu_tab[3] = '{2'b10, 6'b100010, 4'b0110};
    alu_tab[4] = '{2'b10, 6'b100100, 4'b0000};
    alu_tab[5] = '{2'b10, 6'b100101, 4'b0001};
    alu_tab[6] = '{2'b10, 6'b101010, 4'b0111};
    alu_tab[7] = '{2'b10, 6'b100111, 4'b1100};
    alu_tab[8] = '{2'b11, 6'b100010, 4'b0110};
    alu_tab[9] = '{2'b10, 6'b100011, 4'b0000};

    md_tab[0] = '{FN_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
    md_tab[1] = '{FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    md_tab[2] = '{FN_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33};
    md_tab[3] = '{FN_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    md_tab[4] = '{FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    md_tab[5] = '{FN_DIV,   32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1};

    rst_n = 1'b0; alu_op = 2'b00; fn_field = 6'b0; start = 1'b0; src_a = '0; src_b = '0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hilo", {hi, lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      alu_op = alu_tab[i].op; fn_field = alu_tab[i].fn;
      #1;
      check($sformatf("aluctrl[%0d]", i), alu_ctrl, alu_tab[i].ctrl);
    end

    for (int i = 0; i < 6; i++) begin
      issue(md_tab[i].fn, md_tab[i].a, md_tab[i].b);
      wait_done(lat, bc);
      check($sformatf("md_lat[%0d]", i), lat, md_tab[i].lat);
      check($sformatf("md_busycyc[%0d]", i), bc, md_tab[i].lat);
      check($sformatf("md_hilo[%0d]", i), {hi, lo}, {md_tab[i].exp_hi, md_tab[i].exp_lo});
      check($sformatf("md_busy_at_done[%0d]", i), busy, 0);
    end
    @(negedge clk);
    check("done_one_pulse", done, 0);

    // Ops attempted while busy: stall for muldiv/mf/mt only, and no re-latch.
    issue(FN_MULT, 32'hFFFF_FFFD, 32'd5);
    alu_op = 2'b10; start = 1'b1; fn_field = FN_MFLO;
    #1 check("stall_mflo_busy", stall, 1);
    fn_field = FN_ADD;
    #1 check("stall_add_busy", stall, 0);
    check("aluctrl_add_busy", alu_ctrl, 4'b0010);
    fn_field = FN_DIVU; src_a = 32'd9; src_b = 32'd3;
    #1 check("stall_div_busy", stall, 1);
    @(negedge clk);
    start = 1'b0; fn_field = FN_ADD;
    wait_done(lat, bc);
    check("ignored_lat", lat, 32);
    check("ignored_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // Accept a new op in the Done cycle.
    alu_op = 2'b10; fn_field = FN_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; fn_field = FN_ADD;
    check("b2b_busy", busy, 1);
    wait_done(lat, bc);
    check("b2b_lat", lat, 33);
    check("b2b_hilo", {hi, lo}, {32'd2, 32'd14});

    // mthi/mtlo and mfhi/mflo.
    issue(FN_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    start = 1'b1; fn_field = FN_MFHI;
    #1 check("mfhi_data", mf_data, 32'h1234_5678);
    check("mfhi_stall_idle", stall, 0);
    start = 1'b0;
    issue(FN_MTLO, 32'hCAFE_0001, 32'd0);
    start = 1'b1; fn_field = FN_MFLO;
    #1 check("mflo_data", mf_data, 32'hCAFE_0001);
    check("mtlo_keeps_hi", hi, 32'h1234_5678);
    start = 1'b0;

    // Asynchronous reset mid-multiply.
    issue(FN_MULTU, 32'hFFFF_FFFF, 32'd3);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_hilo", {hi, lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("rst_no_done", cnt, 0);
    check("rst_idle_busy", busy, 0);

    fns[0] = FN_MULT; fns[1] = FN_MULTU; fns[2] = FN_DIV; fns[3] = FN_DIVU;
    specials[0] = 32'd0; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h8000_0000;
    specials[3] = 32'd1; specials[4] = 32'h7FFF_FFFF;
    for (int k = 0; k < 60; k++) begin
      logic [5:0] f;
      f  = fns[$urandom_range(0, 3)];
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(16, 31);
      issue(f, ra, rb);
      wait_done(lat, bc);
      exp = model(f, ra, rb);
      check($sformatf("rnd_lat[%0d]", k), lat, ((f == FN_DIV || f == FN_DIVU) && rb == 0) ? 1 : 33);
      check($sformatf("rnd_hilo[%0d] fn=%b a=%h b=%h", k, f, ra, rb), {hi, lo}, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
